// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator driving a req/ack data memory.
// Define MEM_TIMEOUT_EN to abort requests not acknowledged within TIMEOUT cycles.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ALU_Result,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              EX_M_MR,
    input  logic              EX_M_MW,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] ld_data,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-3:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_be;
    logic [DATA_W-1:0] r_ld;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic              r_uns;
`ifdef MEM_TIMEOUT_EN
    logic [3:0]        r_cnt;
`endif

    logic [1:0]        w_off;
    logic              w_aligned;
    logic              w_legal;
    logic              w_bad;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_lane;
    logic [DATA_W-1:0] w_ld;

    assign w_off     = ALU_Result[1:0];
    // Reserved size 11 never counts as aligned, so it falls into the error path.
    assign w_aligned = (size == 2'b00) | ((size == 2'b01) & ~w_off[0]) | ((size == 2'b10) & (w_off == 2'b00));
    assign w_legal   = (EX_M_MR ^ EX_M_MW) & w_aligned;
    assign w_bad     = (EX_M_MR | EX_M_MW) & ~w_legal;

    always_comb begin
        w_be    = (size == 2'b00) ? 4'b0001 << w_off :
                  (size == 2'b01) ? 4'b0011 << w_off : 4'b1111;
        w_wdata = (size == 2'b00) ? {4{Write_Data[7:0]}} :
                  (size == 2'b01) ? {2{Write_Data[15:0]}} : Write_Data;
        w_lane  = mem_rdata >> {r_off, 3'b000};
        w_ld    = (r_size == 2'b00) ? {{24{~r_uns & w_lane[7]}}, w_lane[7:0]} :
                  (r_size == 2'b01) ? {{16{~r_uns & w_lane[15]}}, w_lane[15:0]} : w_lane;
    end

    // Combinational so the pipeline freezes in the same cycle a legal op appears.
    assign stall = rst & (((r_state == IDLE) & w_legal) | (r_state == REQ));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= 4'b0000;
            r_ld    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_off   <= 2'b00;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt   <= 4'd0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_we    <= EX_M_MW;
                        r_addr  <= ALU_Result[ADDR_W-1:2];
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        r_off   <= w_off;
                        r_size  <= size;
                        r_uns   <= ld_unsigned;
`ifdef MEM_TIMEOUT_EN
                        r_cnt   <= 4'd0;
`endif
                    end else if (w_bad) begin
                        r_err <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        if (!r_we)
                            r_ld <= w_ld;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_cnt == 4'(TIMEOUT - 1)) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
`endif
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;
    assign ld_data   = r_ld;
    assign done      = r_done;
    assign err       = r_err;
endmodule
